// File: rtl/mrd_stage_ctrl.sv
// Top-level sequencer for the mixed-radix DFT memory subsystem: sinks one frame, steps the
// butterfly stages against the read/write-back engines, then streams the result out.
module mrd_stage_ctrl #(
    parameter int unsigned WAIT_RD = 4,
    parameter int unsigned wCNT    = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sink_valid,
    input  logic            sink_sop,
    input  logic            sink_eop,
    output logic            sink_ready,
    input  logic [wCNT-1:0] dftpts,
    input  logic [2:0]      num_factors,
    input  logic            rd_end,
    input  logic            wr_end,
    input  logic            source_ready,
    output logic            source_valid,
    output logic            source_sop,
    output logic            source_eop,
    output logic [wCNT-1:0] source_addr,
    output logic [2:0]      fsm,
    output logic [2:0]      fsm_r,
    output logic [2:0]      cnt_stage,
    output logic            busy,
    output logic            sink_err
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSink   = 3'd1,
        StWaitRd = 3'd2,
        StRd     = 3'd3,
        StWaitWr = 3'd4,
        StSource = 3'd5
    } state_e;

    localparam logic [3:0] WaitLoad = 4'(WAIT_RD - 1);

    state_e          state_q, state_d;
    logic [2:0]      fsm_r_q, fsm_r_d;
    logic [2:0]      cnt_stage_q, cnt_stage_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic            wr_pend_q, wr_pend_d;
    logic [wCNT-1:0] dftpts_q, dftpts_d;
    logic [wCNT-1:0] dftpts_m1_q, dftpts_m1_d;
    logic [2:0]      nf_m1_q, nf_m1_d;
    logic [wCNT-1:0] beat_cnt_q, beat_cnt_d;
    logic            source_valid_q, source_valid_d;
    logic            source_sop_q, source_sop_d;
    logic            source_eop_q, source_eop_d;
    logic [wCNT-1:0] source_addr_q, source_addr_d;
    logic            sink_err_q, sink_err_d;

    logic [wCNT-1:0] beat_new;
    logic [wCNT-1:0] dpts_new;
    logic [2:0]      nf_m1_new;

    // A sop beat restarts the count and compares against the freshly sampled length.
    assign beat_new = sink_sop ? wCNT'(1) : beat_cnt_q + wCNT'(1);
    assign dpts_new = sink_sop ? dftpts : dftpts_q;

    always_comb begin
        unique case (num_factors)
            3'd0:    nf_m1_new = 3'd0;
            3'd7:    nf_m1_new = 3'd5;
            default: nf_m1_new = num_factors - 3'd1;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        fsm_r_d        = state_q;
        cnt_stage_d    = cnt_stage_q;
        wait_cnt_d     = wait_cnt_q;
        wr_pend_d      = wr_pend_q;
        dftpts_d       = dftpts_q;
        dftpts_m1_d    = dftpts_m1_q;
        nf_m1_d        = nf_m1_q;
        beat_cnt_d     = beat_cnt_q;
        source_valid_d = source_valid_q;
        source_sop_d   = source_sop_q;
        source_eop_d   = source_eop_q;
        source_addr_d  = source_addr_q;
        sink_err_d     = 1'b0;

        case (state_q)
            StIdle, StSink: begin
                if (sink_valid) begin
                    if (sink_sop) begin
                        dftpts_d    = dftpts;
                        dftpts_m1_d = dftpts - wCNT'(1);
                        nf_m1_d     = nf_m1_new;
                    end
                    // Non-sop beats seen in Idle are dropped.
                    if (sink_sop || state_q == StSink) begin
                        beat_cnt_d = beat_new;
                        if (sink_eop) begin
                            if (beat_new == dpts_new) begin
                                state_d     = StWaitRd;
                                wait_cnt_d  = WaitLoad;
                                cnt_stage_d = 3'd0;
                            end else begin
                                state_d    = StIdle;
                                sink_err_d = 1'b1;
                            end
                        end else begin
                            state_d = StSink;
                        end
                    end
                end
            end
            StWaitRd: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = StRd;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StRd: begin
                if (wr_end) begin
                    wr_pend_d = 1'b1;
                end
                if (rd_end) begin
                    state_d = StWaitWr;
                end
            end
            StWaitWr: begin
                if (wr_end || wr_pend_q) begin
                    wr_pend_d = 1'b0;
                    if (cnt_stage_q == nf_m1_q) begin
                        state_d        = StSource;
                        source_valid_d = 1'b1;
                        source_addr_d  = '0;
                        source_sop_d   = 1'b1;
                        source_eop_d   = (dftpts_m1_q == '0);
                    end else begin
                        state_d     = StWaitRd;
                        wait_cnt_d  = WaitLoad;
                        cnt_stage_d = cnt_stage_q + 3'd1;
                    end
                end
            end
            StSource: begin
                if (source_ready) begin
                    if (source_eop_q) begin
                        state_d        = StIdle;
                        cnt_stage_d    = 3'd0;
                        source_valid_d = 1'b0;
                        source_sop_d   = 1'b0;
                        source_eop_d   = 1'b0;
                        source_addr_d  = '0;
                    end else begin
                        source_addr_d = source_addr_q + wCNT'(1);
                        source_sop_d  = 1'b0;
                        source_eop_d  = (source_addr_q + wCNT'(1) == dftpts_m1_q);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            fsm_r_q        <= 3'd0;
            cnt_stage_q    <= 3'd0;
            wait_cnt_q     <= 4'd0;
            wr_pend_q      <= 1'b0;
            dftpts_q       <= '0;
            dftpts_m1_q    <= '0;
            nf_m1_q        <= 3'd0;
            beat_cnt_q     <= '0;
            source_valid_q <= 1'b0;
            source_sop_q   <= 1'b0;
            source_eop_q   <= 1'b0;
            source_addr_q  <= '0;
            sink_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            fsm_r_q        <= fsm_r_d;
            cnt_stage_q    <= cnt_stage_d;
            wait_cnt_q     <= wait_cnt_d;
            wr_pend_q      <= wr_pend_d;
            dftpts_q       <= dftpts_d;
            dftpts_m1_q    <= dftpts_m1_d;
            nf_m1_q        <= nf_m1_d;
            beat_cnt_q     <= beat_cnt_d;
            source_valid_q <= source_valid_d;
            source_sop_q   <= source_sop_d;
            source_eop_q   <= source_eop_d;
            source_addr_q  <= source_addr_d;
            sink_err_q     <= sink_err_d;
        end
    end

    assign fsm          = state_q;
    assign fsm_r        = fsm_r_q;
    assign cnt_stage    = cnt_stage_q;
    assign source_valid = source_valid_q;
    assign source_sop   = source_sop_q;
    assign source_eop   = source_eop_q;
    assign source_addr  = source_addr_q;
    assign sink_err     = sink_err_q;
    assign sink_ready   = (state_q == StIdle) || (state_q == StSink);
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mrd_stage_ctrl.sv
// Bench for mrd_stage_ctrl: directed scenarios plus randomized frames, checked against
// expectations derived from frame length, stage count and handshake rules.
module tb_mrd_stage_ctrl;

    localparam int WAIT_RD = 4;
    localparam int WCNT    = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sink_valid = 1'b0;
    logic            sink_sop = 1'b0;
    logic            sink_eop = 1'b0;
    logic            sink_ready;
    logic [WCNT-1:0] dftpts = '0;
    logic [2:0]      num_factors = '0;
    logic            rd_end = 1'b0;
    logic            wr_end = 1'b0;
    logic            source_ready = 1'b0;
    logic            source_valid;
    logic            source_sop;
    logic            source_eop;
    logic [WCNT-1:0] source_addr;
    logic [2:0]      fsm;
    logic [2:0]      fsm_r;
    logic [2:0]      cnt_stage;
    logic            busy;
    logic            sink_err;

    int total = 0;
    int bad   = 0;

    mrd_stage_ctrl #(
        .WAIT_RD(WAIT_RD),
        .wCNT   (WCNT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sink_valid  (sink_valid),
        .sink_sop    (sink_sop),
        .sink_eop    (sink_eop),
        .sink_ready  (sink_ready),
        .dftpts      (dftpts),
        .num_factors (num_factors),
        .rd_end      (rd_end),
        .wr_end      (wr_end),
        .source_ready(source_ready),
        .source_valid(source_valid),
        .source_sop  (source_sop),
        .source_eop  (source_eop),
        .source_addr (source_addr),
        .fsm         (fsm),
        .fsm_r       (fsm_r),
        .cnt_stage   (cnt_stage),
        .busy        (busy),
        .sink_err    (sink_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int eff_stages(input int nf);
        if (nf == 0) return 1;
        if (nf == 7) return 6;
        return nf;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_fsm", 32'(fsm), 0);
        chk("rst_fsm_r", 32'(fsm_r), 0);
        chk("rst_stage", 32'(cnt_stage), 0);
        chk("rst_src_valid", 32'(source_valid), 0);
        chk("rst_src_sop", 32'(source_sop), 0);
        chk("rst_src_eop", 32'(source_eop), 0);
        chk("rst_src_addr", 32'(source_addr), 0);
        chk("rst_sink_err", 32'(sink_err), 0);
        chk("rst_sink_ready", 32'(sink_ready), 1);
        chk("rst_busy", 32'(busy), 0);
    endtask

    // Sends nbeats beats for a frame of length n; restart_at>0 first sends a partial frame
    // of restart_at beats which the following sop must discard.
    task automatic send_frame(input int n, input int nf, input int nbeats, input int restart_at);
        int seq_len;
        int pos;
        seq_len = (restart_at > 0) ? restart_at + nbeats : nbeats;
        for (int b = 0; b < seq_len; b++) begin
            pos = (restart_at > 0 && b >= restart_at) ? b - restart_at : b;
            if (b > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    step();
                    chk("gap_sink_ready", 32'(sink_ready), 1);
                end
            end
            sink_valid  = 1'b1;
            sink_sop    = (pos == 0);
            sink_eop    = (pos == nbeats - 1);
            dftpts      = (pos == 0) ? 12'(n) : 12'($urandom);
            num_factors = (pos == 0) ? 3'(nf) : 3'($urandom);
            chk("beat_sink_ready", 32'(sink_ready), 1);
            step();
            sink_valid  = 1'b0;
            sink_sop    = 1'b0;
            sink_eop    = 1'b0;
            dftpts      = 12'($urandom);
            num_factors = 3'($urandom);
            if (pos != nbeats - 1) chk("fsm_sink", 32'(fsm), 1);
        end
        if (nbeats == n) begin
            chk("eop_fsm", 32'(fsm), 2);
            chk("eop_stage", 32'(cnt_stage), 0);
            chk("eop_sink_err", 32'(sink_err), 0);
            chk("eop_sink_ready", 32'(sink_ready), 0);
            chk("eop_busy", 32'(busy), 1);
        end else begin
            chk("err_fsm", 32'(fsm), 0);
            chk("err_pulse", 32'(sink_err), 1);
            chk("err_sink_ready", 32'(sink_ready), 1);
            step();
            chk("err_pulse_end", 32'(sink_err), 0);
            chk("err_fsm_idle", 32'(fsm), 0);
            chk("err_sink_ready2", 32'(sink_ready), 1);
        end
    endtask

    // mode_sel: -1 random, 0 wr_end 3 cycles after rd_end, 1 simultaneous, 2 early wr_end.
    task automatic run_stages(input int nf, input int abort_stage, input int mode_sel);
        int ns;
        int mode;
        int gap;
        ns = eff_stages(nf);
        for (int s = 0; s < ns; s++) begin
            chk("wait_fsm", 32'(fsm), 2);
            chk("wait_stage", 32'(s), 32'(cnt_stage));
            for (int k = 1; k < WAIT_RD; k++) begin
                step();
                chk("wait_hold", 32'(fsm), 2);
            end
            step();
            chk("rd_entry", 32'(fsm), 3);
            chk("rd_first_fsm_r", 32'(fsm_r), 2);
            chk("rd_stage", 32'(cnt_stage), 32'(s));
            if (s == abort_stage) return;
            mode = (mode_sel >= 0) ? mode_sel : $urandom_range(0, 2);
            repeat ($urandom_range(0, 3)) begin
                step();
                chk("rd_hold", 32'(fsm), 3);
            end
            case (mode)
                0: begin
                    gap = (mode_sel >= 0) ? 3 : $urandom_range(1, 4);
                    rd_end = 1'b1;
                    step();
                    rd_end = 1'b0;
                    chk("wwr_entry", 32'(fsm), 4);
                    for (int k = 1; k < gap; k++) begin
                        step();
                        chk("wwr_hold", 32'(fsm), 4);
                    end
                    wr_end = 1'b1;
                    step();
                    wr_end = 1'b0;
                end
                1: begin
                    rd_end = 1'b1;
                    wr_end = 1'b1;
                    step();
                    rd_end = 1'b0;
                    wr_end = 1'b0;
                    chk("sim_wwr", 32'(fsm), 4);
                    step();
                end
                default: begin
                    wr_end = 1'b1;
                    step();
                    wr_end = 1'b0;
                    chk("pend_rd_hold", 32'(fsm), 3);
                    repeat ($urandom_range(0, 2)) begin
                        step();
                        chk("pend_rd_hold2", 32'(fsm), 3);
                    end
                    rd_end = 1'b1;
                    step();
                    rd_end = 1'b0;
                    chk("pend_wwr", 32'(fsm), 4);
                    step();
                end
            endcase
            if (s == ns - 1) begin
                chk("to_source", 32'(fsm), 5);
                chk("src_stage", 32'(cnt_stage), 32'(s));
            end
        end
    endtask

    task automatic run_source(input int n, input bit pattern);
        int a;
        int cyc;
        bit rdy;
        int pat[4];
        pat = '{1, 0, 0, 1};
        a = 0;
        cyc = 0;
        while (a < n && cyc < 1000) begin
            rdy = pattern ? (pat[cyc % 4] != 0) : ($urandom_range(0, 2) != 0);
            source_ready = rdy;
            chk("src_fsm", 32'(fsm), 5);
            chk("src_valid", 32'(source_valid), 1);
            chk("src_addr", 32'(source_addr), 32'(a));
            chk("src_sop", 32'(source_sop), 32'(a == 0));
            chk("src_eop", 32'(source_eop), 32'(a == n - 1));
            step();
            cyc++;
            if (rdy) a++;
        end
        source_ready = 1'b0;
        chk("src_beats", 32'(a), 32'(n));
        chk("done_fsm", 32'(fsm), 0);
        chk("done_valid", 32'(source_valid), 0);
        chk("done_stage", 32'(cnt_stage), 0);
        chk("done_busy", 32'(busy), 0);
        chk("done_sink_ready", 32'(sink_ready), 1);
    endtask

    initial begin
        int n;
        int nf;
        int nb;
        step();
        do_reset();

        // Non-sop beats in Idle are discarded.
        sink_valid = 1'b1;
        sink_eop   = 1'b1;
        step();
        sink_valid = 1'b0;
        sink_eop   = 1'b0;
        chk("idle_discard_fsm", 32'(fsm), 0);
        chk("idle_discard_err", 32'(sink_err), 0);

        send_frame(12, 2, 12, 0);
        run_stages(2, -1, 0);
        run_source(12, 1'b0);

        send_frame(12, 2, 10, 0);

        send_frame(12, 3, 12, 0);
        run_stages(3, -1, 1);
        run_source(12, 1'b0);

        send_frame(16, 1, 16, 0);
        run_stages(1, -1, 2);
        run_source(16, 1'b1);

        send_frame(8, 0, 8, 0);
        run_stages(0, -1, -1);
        run_source(8, 1'b0);

        send_frame(6, 7, 6, 0);
        run_stages(7, -1, -1);
        run_source(6, 1'b0);

        send_frame(10, 3, 10, 4);
        run_stages(3, -1, -1);
        run_source(10, 1'b0);

        send_frame(9, 4, 9, 0);
        run_stages(4, 2, -1);
        do_reset();
        send_frame(9, 3, 9, 0);
        run_stages(3, -1, -1);
        run_source(9, 1'b0);

        for (int r = 0; r < 8; r++) begin
            n  = $urandom_range(2, 24);
            nf = $urandom_range(0, 7);
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 26) : n;
            send_frame(n, nf, nb, 0);
            if (nb == n) begin
                run_stages(nf, -1, -1);
                run_source(n, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
